uart_tx_feeder: RTL
===================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter BUSY_TMO, default 32, clk cycles to wait for tx_busy before re-strobing.
REQ-003 SHALL have port clk  input  1  UART clock (16x baud), same clock as the transmitter.
REQ-004 SHALL have port rst  input  1  reset; one clock; synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  push wr_data into FIFO when high and full low.
REQ-006 SHALL have port wr_data  input  8  byte to queue.
REQ-007 SHALL have port full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port level  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-010 SHALL have port tx_data  output  8  byte presented to transmitter datain.
REQ-011 SHALL have port tx_wr  output  1  transmitter wrsig; the transmitter starts on its rising edge.
REQ-012 SHALL have port tx_busy  input  1  transmitter idle output; high = line busy.
REQ-013 SHALL have port active  output  1  high whenever FSM is not in S_IDLE.

Function
REQ-014 FIFO SHALL be a circular buffer with DEPTH_LOG2-bit read/write pointers that wrap from 2**DEPTH_LOG2-1 to 0; level SHALL be updated registered, one cycle after the push or pop.
REQ-015 A push while full SHALL be ignored, leaving FIFO contents and level unchanged; a push and a pop in the same cycle SHALL leave level unchanged.
REQ-016 FSM states SHALL be S_IDLE, S_LOAD, S_STROBE, S_WAIT_BUSY and S_WAIT_DONE.
REQ-017 S_IDLE -> S_LOAD when empty is low and tx_busy is low; otherwise the FSM SHALL remain in S_IDLE.
REQ-018 S_LOAD SHALL pop one byte into the tx_data register (level decrements) and then go to S_STROBE.
REQ-019 S_STROBE SHALL drive tx_wr high for exactly 4 cycles and then go to S_WAIT_BUSY.
REQ-020 S_WAIT_BUSY SHALL drive tx_wr low; on tx_busy=1 it SHALL go to S_WAIT_DONE; after BUSY_TMO cycles without tx_busy it SHALL return to S_STROBE (retry, same byte, no pop).
REQ-021 S_WAIT_DONE SHALL go to S_IDLE on tx_busy=0.
REQ-022 tx_data SHALL be held stable from S_LOAD exit until the next S_LOAD, because the transmitter samples datain throughout the frame.
REQ-023 tx_wr SHALL be low in every state except S_STROBE, guaranteeing a low phase of at least 1 cycle between strobes.
REQ-024 A write into an empty FIFO SHALL make empty low on the following cycle; the FSM SHALL leave S_IDLE no earlier than that cycle.
REQ-025 Back-to-back bytes SHALL be separated by at least one S_IDLE cycle after tx_busy falls.

Reset
REQ-026 With rst high at a clk edge, the block SHALL set pointers=0, level=0, empty=1, full=0, tx_data=8'h00, tx_wr=0, active=0 and state=S_IDLE.
REQ-027 Reset mid-frame SHALL discard queued bytes and the byte in flight; the transmitter may finish its current frame, and the FSM SHALL not strobe again until tx_busy is low.

Configuration
REQ-028 With macro UART_TX_FEEDER_OVF_EN defined, the block SHALL add output ovf (1 bit, sticky, set by a push while full) and input ovf_clr (clears ovf; if a set and a clear occur in the same cycle, set wins); ovf SHALL reset to 0.
REQ-029 Without UART_TX_FEEDER_OVF_EN, the ports ovf and ovf_clr SHALL be absent and pushes while full SHALL be silently dropped.

Verification
REQ-030 Push 8'hA5 with tx_busy model responding 3 cycles after the tx_wr rise and holding 153 cycles -> tx_wr high 4 cycles, tx_data=8'hA5 for the whole frame, active returns to 0, level returns to 0.
REQ-031 Push 8'h01,8'h02,8'h03 back-to-back -> three strobes in order 01,02,03, each strobe only after tx_busy has been low for at least 1 cycle.
REQ-032 Push 17 bytes with the transmitter held busy -> full=1 at level 16, 17th byte dropped, ovf=1 (macro on); ovf_clr pulse -> ovf=0.
REQ-033 tx_busy never rises -> tx_wr re-strobes every 4+BUSY_TMO cycles with the same tx_data, and level does not decrement again.
REQ-034 Pointer wrap: push/pop 40 bytes 8'h00..8'h27 -> transmitted sequence matches in order, with no loss.
REQ-035 Assert rst during S_WAIT_DONE with 5 bytes queued -> next cycle level=0, empty=1, tx_wr=0, active=0.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a strobe-started UART transmitter, re-strobing on busy timeout.
// Define UART_TX_FEEDER_OVF_EN to add the sticky overflow flag (ovf) and its clear input (ovf_clr).
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_TMO   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_busy,
    output logic                  active
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    output logic                  ovf,
    input  logic                  ovf_clr
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(BUSY_TMO + 4);

    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0]      CNT_ONE = 1;
    localparam logic [CNT_W-1:0]      STROBE_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0]      TMO_LAST = CNT_W'(BUSY_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  push;
    logic                  pop;

    assign full   = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty  = (level == '0);
    assign push   = wr_en && !full;
    assign pop    = (state == S_LOAD) && !empty;
    assign active = (state != S_IDLE);
    assign tx_wr  = (state == S_STROBE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            tx_data <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                tx_data <= mem[rd_ptr];
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // One shared counter times both the strobe width and the busy timeout; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (cnt == STROBE_LAST) begin
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = S_STROBE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_FEEDER_OVF_EN
    // A dropped push in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule
